clk_div_multi: RTL and testbench
================================

# clk_div_multi

Parametrised multi-channel successor to the single-channel clock divider. Generates CHANNELS independent divided clocks from one input clock. Each channel has its own divisor, a glitch-free enable, a one-cycle tick strobe and a shared phase-sync input. It sits next to the system clock source and feeds peripherals that need slow clocks or clock enables.

## Interface
- WIDTH, 16: divisor and counter width; ratio N = divisor+1, range 1..2^WIDTH
- CHANNELS, 4: number of independent divider channels
- clkin  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- en  in  CHANNELS  per-channel run enable
- divisor  in  CHANNELS*WIDTH  per-channel divisor; channel k uses bits [k*WIDTH +: WIDTH]
- sync  in  1  phase-align strobe for all channels
- clkout  out  CHANNELS  registered divided clock per channel
- tick  out  CHANNELS  one-cycle pulse coincident with each clkout rising period start
- active  out  CHANNELS  channel running (not idle)

## Operation
- Per channel: counter cnt (WIDTH bits), latched divisor dl (WIDTH bits), state IDLE/RUN.
- High time H = (dl>>1)+1 cycles = ceil(N/2); low time N−H. Even N gives 50% duty; odd N is high one cycle longer than low.
- In RUN: cnt counts 0..dl, then wraps to 0. clkout=1 while cnt<H; tick=1 only when cnt==0.
- Boundary = edge where cnt==dl in RUN. At a boundary:
  - en=1: cnt←0, dl←current divisor, clkout←1, tick←1.
  - en=0: go IDLE.
  - Divisor changes between boundaries have no effect; a change is never a runt or a stretched pulse.
- IDLE: clkout=0, tick=0, active=0, cnt held at 0. Any edge with en=1 enters RUN with cnt=0, dl←divisor, clkout=1, tick=1.
- Deasserting en mid-period completes the current period, then the channel stops low.
- sync=1 at an edge acts on every channel:
  - en=1 channels restart (cnt=0, dl←divisor, clkout=1, tick=1).
  - en=0 channels go IDLE immediately.
- Priority: reset > sync > boundary/IDLE start > count.
- divisor=0 (N=1): H=1 and every edge is a boundary. clkout stays 1 and tick is 1 every cycle.
- Counter arithmetic is WIDTH-bit unsigned. H cannot overflow. divisor=2^WIDTH−1 gives N=2^WIDTH.

## Timing
- Reset (reset=0 sampled): all channels IDLE; clkout=0, tick=0, active=0, cnt=0, dl=0.
- First edge with reset=1 and en=1: clkout=1, tick=1, active=1 on that edge. There is zero added latency from en to the first rising edge.
- Outputs are flops; no combinational path from inputs to outputs.
- clkout period is exactly N clkin cycles. Rising edges are spaced N cycles apart and are coincident with tick.
- A divisor change takes effect at the first boundary after the change. That period and all later ones use the new N.
- Reset asserted mid-period: outputs go low on that edge. There is no completion of the period.
- Channels with the same N, started by the same sync or the same edge, stay phase-locked indefinitely.

## Structure
- Shared header clk_div_defs.vh: default WIDTH, default CHANNELS, IDLE/RUN state encodings.
- Sub-module clk_div_chan holds one channel (counter, latch, state, output flops). The top is a generate loop of CHANNELS instances plus port slicing.

## Test plan
- Reset, then en[0]=1 with divisor=5 → clkout[0] period 6, high 3 / low 3; tick every 6 cycles; first tick on the first edge after reset release.
- divisor=4 → period 5, high 3 / low 2. Change divisor 4→8 mid-period → current period finishes at 5 cycles, next period is 9 (high 5 / low 4), with no runt.
- Drop en mid-period at cnt=2 with N=6 → clkout holds through cnt=5, then stays 0; active drops at that boundary; tick stays 0.
- Channels 0..3 with divisors 1, 2, 3, 9 running for ~100 cycles, then a sync pulse → on that edge all four clkout=1 and tick=1 together; periods 2, 3, 4, 10 resume from there.
- divisor=0 → clkout constant 1, tick every cycle. divisor=16'hFFFF → period 65536, high 32768.
- Reset pulse (reset=0 for 3 cycles) mid-run on all channels → all outputs 0 during reset; restart on the first edge after release. Also: sync and boundary on the same edge → sync outcome wins.

Source files
------------

// File: rtl/clk_div_multi_pkg.sv
// clk_div_multi_pkg
//   Shared definitions for the multi-channel clock divider: default
//   parameter values, per-channel state encoding and the high-time helper.
package clk_div_multi_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

    // High time in cycles for a latched divisor: ceil(N/2) = (dl>>1)+1.
    // The shift frees the top bit, so the +1 can never overflow WIDTH bits.
    function automatic logic [DEF_WIDTH-1:0] high_time(input logic [DEF_WIDTH-1:0] dl);
        return (dl >> 1) + DEF_WIDTH'(1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan
//   One divider channel: counter, latched divisor, IDLE/RUN state and
//   registered clkout/tick/active flops.
//   Ports:
//     clk_i     input clock (rising edge)
//     rst_ni    synchronous active-low reset
//     en_i      run enable; deassertion finishes the current period
//     sync_i    phase-align strobe (restart if enabled, else stop now)
//     div_i     divisor, ratio N = div_i+1, sampled only at period starts
//     clkout_o  divided clock
//     tick_o    one-cycle strobe at each period start
//     active_o  channel is running
module clk_div_chan
    import clk_div_multi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic [WIDTH-1:0] div_i,
    output logic             clkout_o,
    output logic             tick_o,
    output logic             active_o
);

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dl_q, dl_d;
    logic             clkout_q, clkout_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] hi_time;
    logic             boundary;

    assign cnt_inc  = cnt_q + WIDTH'(1);
    assign hi_time  = (dl_q >> 1) + WIDTH'(1);
    assign boundary = (state_q == ST_RUN) && (cnt_q == dl_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dl_d     = dl_q;
        clkout_d = clkout_q;
        tick_d   = 1'b0;

        if (sync_i || state_q == ST_IDLE || boundary) begin
            // Every period start (sync, idle start, boundary) shares this path;
            // sync stops a disabled channel immediately, the others only
            // stop once the running period is complete.
            cnt_d = '0;
            if (en_i) begin
                state_d  = ST_RUN;
                dl_d     = div_i;
                clkout_d = 1'b1;
                tick_d   = 1'b1;
            end else begin
                state_d  = ST_IDLE;
                clkout_d = 1'b0;
            end
        end else begin
            // Mid-period: cnt < dl here, so cnt+1 cannot wrap.
            cnt_d    = cnt_inc;
            clkout_d = (cnt_inc < hi_time);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dl_q     <= '0;
            clkout_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dl_q     <= dl_d;
            clkout_q <= clkout_d;
            tick_q   <= tick_d;
        end
    end

    assign clkout_o = clkout_q;
    assign tick_o   = tick_q;
    assign active_o = (state_q == ST_RUN);

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi
//   CHANNELS independent glitch-free clock dividers sharing one input clock
//   and one phase-sync strobe.
//   Ports:
//     clkin    input clock (rising edge)
//     reset    synchronous active-low reset
//     en       per-channel run enable
//     divisor  per-channel divisor, channel k at [k*WIDTH +: WIDTH]
//     sync     phase-align strobe for all channels
//     clkout   per-channel divided clock (registered)
//     tick     per-channel period-start strobe (registered)
//     active   per-channel running flag (registered state)
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                      clkin,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] divisor,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clkout,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       active
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        clk_div_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk_i   (clkin),
            .rst_ni  (reset),
            .en_i    (en[k]),
            .sync_i  (sync),
            .div_i   (divisor[k*WIDTH +: WIDTH]),
            .clkout_o(clkout[k]),
            .tick_o  (tick[k]),
            .active_o(active[k])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi
//   Directed bench for clk_div_multi with hand-computed expected patterns.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_clk_div_multi;

    localparam int W = 16;
    localparam int C = 4;

    logic           clkin;
    logic           reset;
    logic [C-1:0]   en;
    logic [C*W-1:0] divisor;
    logic           sync;
    logic [C-1:0]   clkout;
    logic [C-1:0]   tick;
    logic [C-1:0]   active;

    int checks = 0;
    int errors = 0;

    clk_div_multi #(.WIDTH(W), .CHANNELS(C)) dut (
        .clkin  (clkin),
        .reset  (reset),
        .en     (en),
        .divisor(divisor),
        .sync   (sync),
        .clkout (clkout),
        .tick   (tick),
        .active (active)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic set_div(input int k, input logic [W-1:0] v);
        divisor[k*W +: W] = v;
    endtask

    logic [31:0] cs, ts, as;
    logic [14:0] cv [C];
    logic [14:0] tv [C];
    logic [14:0] ce [C];
    logic [14:0] te [C];
    int          nn [C];
    int          hi, per;

    initial begin
        reset = 1'b0; en = '0; divisor = '0; sync = 1'b0;
        step(); step();
        chk("rst_clkout", 64'(clkout), 64'h0);
        chk("rst_tick",   64'(tick),   64'h0);
        chk("rst_active", 64'(active), 64'h0);

        // N=6 on ch0, enabled on the first edge after release
        reset = 1'b1; en = 4'b0001; set_div(0, 16'd5);
        cs = '0; ts = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            cs[i] = clkout[0]; ts[i] = tick[0];
        end
        chk("n6_clk",  64'(cs[11:0]), 64'h1C7);
        chk("n6_tick", 64'(ts[11:0]), 64'h041);

        // N=5 then change 4->8 mid-period at cnt=2
        set_div(0, 16'd4);
        cs = '0; ts = '0;
        for (int i = 0; i < 14; i++) begin
            step();
            cs[i] = clkout[0]; ts[i] = tick[0];
            if (i == 2) set_div(0, 16'd8);
        end
        chk("n5_n9_clk",  64'(cs[13:0]), 64'h03E7);
        chk("n5_n9_tick", 64'(ts[13:0]), 64'h0021);

        // N=6, drop en at cnt=2: period completes then channel stops low
        set_div(0, 16'd5);
        cs = '0; ts = '0; as = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            cs[i] = clkout[0]; ts[i] = tick[0]; as[i] = active[0];
            if (i == 2) en[0] = 1'b0;
        end
        chk("stop_clk",    64'(cs[9:0]), 64'h007);
        chk("stop_tick",   64'(ts[9:0]), 64'h001);
        chk("stop_active", 64'(as[9:0]), 64'h03F);

        // four channels N=2,3,4,10, then sync at a misaligned point
        set_div(0, 16'd1); set_div(1, 16'd2); set_div(2, 16'd3); set_div(3, 16'd9);
        nn[0] = 2; nn[1] = 3; nn[2] = 4; nn[3] = 10;
        en = 4'hF;
        for (int i = 0; i <= 100; i++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_clk",  64'(clkout), 64'hF);
        chk("sync_tick", 64'(tick),   64'hF);
        for (int k = 0; k < C; k++) begin
            cv[k] = '0; tv[k] = '0; ce[k] = '0; te[k] = '0;
            cv[k][0] = clkout[k]; tv[k][0] = tick[k];
        end
        for (int i = 1; i < 15; i++) begin
            step();
            for (int k = 0; k < C; k++) begin
                cv[k][i] = clkout[k]; tv[k][i] = tick[k];
            end
        end
        for (int k = 0; k < C; k++) begin
            for (int i = 0; i < 15; i++) begin
                ce[k][i] = ((i % nn[k]) < (nn[k] + 1) / 2);
                te[k][i] = ((i % nn[k]) == 0);
            end
            chk($sformatf("multi_clk%0d", k),  64'(cv[k]), 64'(ce[k]));
            chk($sformatf("multi_tick%0d", k), 64'(tv[k]), 64'(te[k]));
        end

        // sync on ch1's boundary with en=0 and ch3 mid-period with en=0
        en = 4'b0101; sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_win_clk",    64'(clkout), 64'h5);
        chk("sync_win_tick",   64'(tick),   64'h5);
        chk("sync_win_active", 64'(active), 64'h5);

        // divisor 0 on ch0: constant high, tick every cycle
        set_div(0, 16'd0);
        step(); step();
        cs = '0; ts = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            cs[i] = clkout[0]; ts[i] = tick[0];
        end
        chk("n1_clk",  64'(cs[7:0]), 64'hFF);
        chk("n1_tick", 64'(ts[7:0]), 64'hFF);

        // reset pulse mid-run, then restart on the first edge after release
        en = 4'hF; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst%0d_out", i), 64'({clkout, tick, active}), 64'h0);
        end
        reset = 1'b1;
        step();
        chk("restart_clk",    64'(clkout), 64'hF);
        chk("restart_tick",   64'(tick),   64'hF);
        chk("restart_active", 64'(active), 64'hF);

        // max divisor on ch1: high 32768, period 65536
        set_div(1, 16'hFFFF); en = 4'b0010; sync = 1'b1;
        step();
        sync = 1'b0;
        chk("max_start", 64'({clkout, tick}), 64'h22);
        hi = 1;
        while (clkout[1] === 1'b1 && hi < 70000) begin
            step();
            if (clkout[1] === 1'b1) hi++;
        end
        chk("max_high", 64'(hi), 64'd32768);
        per = hi;
        while (tick[1] !== 1'b1 && per < 70000) begin
            step();
            per++;
        end
        chk("max_period", 64'(per), 64'd65536);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
